sprite_reg_ctrl: RTL and testbench
==================================

SPRITE_REG_CTRL -- requirements
Module: sprite_reg_ctrl

Interface
REQ-001 SHALL have parameter ANIM_FRAMES, default 6: frames per walk-animation step.
REQ-002 SHALL have parameter SCORE_FRAMES, default 6: frames per score increment.
REQ-003 SHALL have port clk, input, 1: the single clock, 50 MHz; one clock only.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have ports chipselect, write (input, 1), address (input, 9) and writedata (input, 32): bus write port, one write per cycle when chipselect && write.
REQ-006 SHALL have ports hcount (input, 11) and vcount (input, 10): raster position from the VGA timing counters.
REQ-007 SHALL have outputs spr_x[5] (11 each) and spr_y[5] (10 each): active positions for sprite index 0-4 (dino, jump, duck, cactus, godzilla).
REQ-008 SHALL have outputs score_x (11) and score_y (10): active score position.
REQ-009 SHALL have output score_digits[3] (4 each): BCD score, index 0 = ones.
REQ-010 SHALL have outputs sprite_state (2): walk frame select 0..2; and commit (1): one-cycle pulse on each shadow-to-active copy.

Function
REQ-011 Write address map SHALL be 0-9 spr x/y pairs (even = x, odd = y), 10 score_x, 11 score_y, 12 control (bit0 run, bit1 clear_score), 13 anim_div (writedata[3:0], 0 treated as 1); other addresses ignored.
REQ-012 Writes to 0-11 SHALL land only in shadow registers; active outputs SHALL NOT change during active video.
REQ-013 FSM SHALL use states ACTIVE, COMMIT, UPDATE, BLANK.
REQ-014 ACTIVE->COMMIT SHALL occur on the cycle where vcount==480 && hcount==0.
REQ-015 COMMIT SHALL last one cycle: copy all shadow registers to active and assert commit.
REQ-016 UPDATE SHALL last one cycle: advance frame counters, score and sprite_state.
REQ-017 BLANK->ACTIVE SHALL occur when vcount==0 && hcount==0.
REQ-018 A write in the COMMIT cycle SHALL update shadow only; the active copy takes the pre-write shadow value, and the new value commits next frame.
REQ-019 Control writes (address 12, 13) SHALL take effect immediately; clear_score is a self-clearing strobe that zeros the score at the next UPDATE.
REQ-020 The anim counter SHALL count UPDATEs while run=1; on reaching ANIM_FRAMES*anim_div, sprite_state SHALL advance 0->1->2->0 and the counter SHALL reset.
REQ-021 While run=0, sprite_state and the anim counter SHALL hold.
REQ-022 Score SHALL be 3-digit BCD, wrap 999->000, no invalid BCD ever output.
REQ-023 If clear_score and an increment fall in the same UPDATE, clear SHALL win: score = 000.
REQ-024 The latency of every output SHALL be registered, with no combinational path from bus inputs to outputs.

Reset
REQ-025 When reset=0 at a clk edge, the FSM SHALL enter ACTIVE and outputs SHALL reset to: spr_x = {100,200,300,500,100}; spr_y = {100,150,200,100,260}; score_x=1184; score_y=448; score=000; sprite_state=0; commit=0.
REQ-026 Reset SHALL set shadow registers equal to active, run=0, anim_div=1, and clear counters.
REQ-027 Reset asserted mid-frame SHALL abort any state, and a pending write in the reset cycle SHALL be dropped.

Configuration
REQ-028 With macro SCORE_AUTO_EN defined, score SHALL increment every SCORE_FRAMES UPDATEs while run=1.
REQ-029 Without SCORE_AUTO_EN, there SHALL be no auto-increment; address 14 SHALL write the BCD score (writedata[11:0], digits >9 clamp to 9), applied at the next UPDATE; clear_score still wins.

Structure
REQ-030 Package vga_game_pkg SHALL hold the register address constants, the xcoord_t (11-bit) and ycoord_t (10-bit) typedefs, bcd_t (4-bit), the FSM state enum and the reset position constants.
REQ-031 Sub-module bcd_counter3 SHALL be used: synchronous clear, increment, and, without SCORE_AUTO_EN, load; it wraps 999->000.

Verification
REQ-032 Write addr 0 = 400 at vcount=100, then check: spr_x[0] stays 100 until vcount=480/hcount=0; it becomes 400 one cycle after COMMIT, and commit pulses exactly once.
REQ-033 Write addr 1 = 50 in the COMMIT cycle, then check: spr_y[0] unchanged this frame and equal to 50 after the next frame's commit.
REQ-034 With SCORE_AUTO_EN, run=1 and SCORE_FRAMES=6, preload 998, then check: 999 after 6 frames and 000 after 12.
REQ-035 Set run=1 and anim_div=2, then check: sprite_state sequence 0,1,2,0 changes every 12 frames; setting run=0 freezes it.
REQ-036 Assert clear_score in the same frame an increment is due, then check: score = 000, not 001.
REQ-037 Assert reset=0 for one cycle during COMMIT, then check: all outputs hold reset values, the FSM is ACTIVE, and no commit pulse occurs.

Source files
------------

// File: rtl/vga_game_pkg.sv
// Shared types, register map and reset positions for the VGA game sprite register block.
// Latency: n/a (package); backpressure: n/a.
package vga_game_pkg;

  typedef logic [10:0] xcoord_t;
  typedef logic [9:0]  ycoord_t;
  typedef logic [3:0]  bcd_t;

  typedef enum logic [1:0] {ACTIVE, COMMIT, UPDATE, BLANK} state_t;

  localparam int NUM_SPR = 5;

  localparam logic [8:0] ADDR_SCORE_X  = 9'd10;
  localparam logic [8:0] ADDR_SCORE_Y  = 9'd11;
  localparam logic [8:0] ADDR_CTRL     = 9'd12;
  localparam logic [8:0] ADDR_ANIM_DIV = 9'd13;
  localparam logic [8:0] ADDR_SCORE    = 9'd14;

  localparam ycoord_t VBLANK_LINE = 10'd480;

  // Sprite order: dino, jump, duck, cactus, godzilla.
  localparam xcoord_t RST_SPR_X [NUM_SPR] = '{11'd100, 11'd200, 11'd300, 11'd500, 11'd100};
  localparam ycoord_t RST_SPR_Y [NUM_SPR] = '{10'd100, 10'd150, 10'd200, 10'd100, 10'd260};
  localparam xcoord_t RST_SCORE_X = 11'd1184;
  localparam ycoord_t RST_SCORE_Y = 10'd448;

  function automatic bcd_t bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD score counter: clear beats load beats increment, wraps 999->000; 1-cycle latency, no backpressure.
// SCORE_AUTO_EN removes the load path (score only advances by increment).
module bcd_counter3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
`ifndef SCORE_AUTO_EN
  input  logic        load,
  input  logic [11:0] load_val,
`endif
  output logic [3:0]  digits [3]
);
  import vga_game_pkg::*;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < 3; i++) digits[i] <= 4'd0;
    end
`ifndef SCORE_AUTO_EN
    else if (load) begin
      for (int i = 0; i < 3; i++) digits[i] <= bcd_clamp(load_val[4*i +: 4]);
    end
`endif
    else if (inc) begin
      if (digits[0] != 4'd9) begin
        digits[0] <= digits[0] + 4'd1;
      end else begin
        digits[0] <= 4'd0;
        if (digits[1] != 4'd9) begin
          digits[1] <= digits[1] + 4'd1;
        end else begin
          digits[1] <= 4'd0;
          digits[2] <= (digits[2] == 4'd9) ? 4'd0 : digits[2] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_reg_ctrl.sv
// Shadowed sprite/score registers committed once per frame at vblank, plus walk animation and score; all outputs registered, writes always accepted.
// SCORE_AUTO_EN: score auto-increments every SCORE_FRAMES frames instead of being loaded via address 14.
module sprite_reg_ctrl #(
  parameter int ANIM_FRAMES  = 6,
  parameter int SCORE_FRAMES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [8:0]  address,
  input  logic [31:0] writedata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [10:0] spr_x [5],
  output logic [9:0]  spr_y [5],
  output logic [10:0] score_x,
  output logic [9:0]  score_y,
  output logic [3:0]  score_digits [3],
  output logic [1:0]  sprite_state,
  output logic        commit
);
  import vga_game_pkg::*;

  localparam int ANIM_W = $clog2(ANIM_FRAMES * 15 + 1);

  state_t            state, state_nxt;
  xcoord_t           sh_x [NUM_SPR];
  ycoord_t           sh_y [NUM_SPR];
  xcoord_t           sh_score_x;
  ycoord_t           sh_score_y;
  logic              run;
  logic              clr_pend;
  logic [3:0]        anim_div;
  logic [3:0]        div_eff;
  logic [ANIM_W-1:0] anim_cnt;
  logic [ANIM_W-1:0] anim_lim;
  logic              anim_hit;
  logic              wr;
  logic              score_inc;
  logic              unused_bits;

  assign wr          = chipselect && write;
  assign unused_bits = ^writedata;

`ifdef SCORE_AUTO_EN
  localparam int SC_W = $clog2(SCORE_FRAMES + 1);
  logic [SC_W-1:0] score_cnt;
  logic            score_hit;
  assign score_hit = (score_cnt + SC_W'(1)) >= SC_W'(SCORE_FRAMES);
  assign score_inc = (state == UPDATE) && run && score_hit;
`else
  logic        ld_pend;
  logic [11:0] ld_val;
  assign score_inc = 1'b0;
`endif

  always_comb begin
    div_eff  = (anim_div == 4'd0) ? 4'd1 : anim_div;
    anim_lim = ANIM_W'(ANIM_FRAMES) * ANIM_W'(div_eff);
    anim_hit = (anim_cnt + ANIM_W'(1)) >= anim_lim;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (vcount == VBLANK_LINE && hcount == 11'd0) state_nxt = COMMIT;
      COMMIT:  state_nxt = UPDATE;
      UPDATE:  state_nxt = BLANK;
      BLANK:   if (vcount == 10'd0 && hcount == 11'd0) state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ACTIVE;
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x[i]  <= RST_SPR_X[i];
        sh_y[i]  <= RST_SPR_Y[i];
        spr_x[i] <= RST_SPR_X[i];
        spr_y[i] <= RST_SPR_Y[i];
      end
      sh_score_x   <= RST_SCORE_X;
      sh_score_y   <= RST_SCORE_Y;
      score_x      <= RST_SCORE_X;
      score_y      <= RST_SCORE_Y;
      commit       <= 1'b0;
      run          <= 1'b0;
      anim_div     <= 4'd1;
      clr_pend     <= 1'b0;
      anim_cnt     <= '0;
      sprite_state <= 2'd0;
`ifdef SCORE_AUTO_EN
      score_cnt    <= '0;
`else
      ld_pend      <= 1'b0;
      ld_val       <= 12'd0;
`endif
    end else begin
      state  <= state_nxt;
      commit <= (state == COMMIT);

      // Copy uses the pre-write shadow; a same-cycle write lands in shadow for next frame.
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          spr_x[i] <= sh_x[i];
          spr_y[i] <= sh_y[i];
        end
        score_x <= sh_score_x;
        score_y <= sh_score_y;
      end

      if (state == UPDATE) begin
        clr_pend <= 1'b0;
        if (run) begin
          if (anim_hit) begin
            anim_cnt     <= '0;
            sprite_state <= (sprite_state == 2'd2) ? 2'd0 : sprite_state + 2'd1;
          end else begin
            anim_cnt <= anim_cnt + ANIM_W'(1);
          end
        end
`ifdef SCORE_AUTO_EN
        if (run) score_cnt <= score_hit ? '0 : score_cnt + SC_W'(1);
`else
        ld_pend <= 1'b0;
`endif
      end

      if (wr) begin
        if (address < ADDR_SCORE_X) begin
          if (address[0]) sh_y[address[3:1]] <= writedata[9:0];
          else            sh_x[address[3:1]] <= writedata[10:0];
        end else begin
          case (address)
            ADDR_SCORE_X:  sh_score_x <= writedata[10:0];
            ADDR_SCORE_Y:  sh_score_y <= writedata[9:0];
            ADDR_CTRL: begin
              run <= writedata[0];
              if (writedata[1]) clr_pend <= 1'b1;
            end
            ADDR_ANIM_DIV: anim_div <= writedata[3:0];
`ifndef SCORE_AUTO_EN
            ADDR_SCORE: begin
              ld_pend <= 1'b1;
              ld_val  <= writedata[11:0];
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  bcd_counter3 u_score (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state == UPDATE) && clr_pend),
    .inc      (score_inc),
`ifndef SCORE_AUTO_EN
    .load     ((state == UPDATE) && ld_pend),
    .load_val (ld_val),
`endif
    .digits   (score_digits)
  );

endmodule

// File: tb/tb_sprite_reg_ctrl.sv
// Directed bench for sprite_reg_ctrl with a scoreboard of expected values; SCORE_AUTO_EN selects the score sequence.
`timescale 1ns/1ps
module tb_sprite_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [10:0] spr_x [5];
  logic [9:0]  spr_y [5];
  logic [10:0] score_x;
  logic [9:0]  score_y;
  logic [3:0]  score_digits [3];
  logic [1:0]  sprite_state;
  logic        commit;

  int n_chk = 0;
  int n_fail = 0;
  int n_commit = 0;
  int c0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int exp_x [5] = '{100, 200, 300, 500, 100};
  int exp_y [5] = '{100, 150, 200, 100, 260};

  sprite_reg_ctrl #(.ANIM_FRAMES(6), .SCORE_FRAMES(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .hcount       (hcount),
    .vcount       (vcount),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .score_x      (score_x),
    .score_y      (score_y),
    .score_digits (score_digits),
    .sprite_state (sprite_state),
    .commit       (commit)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (commit === 1'b1) n_commit++;

  initial begin
    #(10_000_000);
    $display("FAIL timeout n_chk=%0d n_fail=%0d", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] score_val();
    return {20'd0, score_digits[2], score_digits[1], score_digits[0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  // One compressed frame; optional write and/or reset driven in the COMMIT cycle.
  task automatic frame(input bit cw, input logic [8:0] a, input logic [31:0] d, input bit crst);
    hcount = 11'd0; vcount = 10'd480;
    tick();
    hcount = 11'd1; vcount = 10'd481;
    if (cw) begin chipselect = 1'b1; write = 1'b1; address = a; writedata = d; end
    if (crst) reset = 1'b0;
    tick();
    chipselect = 1'b0; write = 1'b0; reset = 1'b1;
    tick();
    hcount = 11'd0; vcount = 10'd0;
    tick();
    hcount = 11'd5; vcount = 10'd100;
    tick();
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    hcount = 11'd5; vcount = 10'd100;
    tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    for (int i = 0; i < 5; i++) begin
      push($sformatf("%s_spr_x%0d", pfx, i), exp_x[i]); pop_check(spr_x[i]);
      push($sformatf("%s_spr_y%0d", pfx, i), exp_y[i]); pop_check(spr_y[i]);
    end
    push({pfx, "_score_x"}, 1184);   pop_check(score_x);
    push({pfx, "_score_y"}, 448);    pop_check(score_y);
    push({pfx, "_score"}, 0);        pop_check(score_val());
    push({pfx, "_sprite_state"}, 0); pop_check(sprite_state);
    push({pfx, "_commit"}, 0);       pop_check(commit);
  endtask

  initial begin
    do_reset();
    check_reset_vals("reset");

    // Shadow write during active video must not reach the output until the commit.
    c0 = n_commit;
    bus_write(9'd0, 32'd400);
    push("x0_active_video", 100); pop_check(spr_x[0]);
    hcount = 11'd0; vcount = 10'd480;
    tick();
    push("x0_commit_cycle", 100); pop_check(spr_x[0]);
    hcount = 11'd1; vcount = 10'd481;
    tick();
    push("x0_after_commit", 400); pop_check(spr_x[0]);
    push("commit_high", 1);       pop_check(commit);
    tick();
    push("commit_low", 0);        pop_check(commit);
    hcount = 11'd0; vcount = 10'd0;
    tick();
    hcount = 11'd5; vcount = 10'd100;
    tick();
    push("commit_pulses", 1);     pop_check(n_commit - c0);

    // Write in the COMMIT cycle goes to next frame.
    frame(1'b1, 9'd1, 32'd50, 1'b0);
    push("y0_same_frame", 100);   pop_check(spr_y[0]);
    frame(1'b0, '0, '0, 1'b0);
    push("y0_next_frame", 50);    pop_check(spr_y[0]);
    push("x0_held", 400);         pop_check(spr_x[0]);

    bus_write(9'd10, 32'd640);
    bus_write(9'd11, 32'd32);
    bus_write(9'd9, 32'd77);
    bus_write(9'd15, 32'd5);
    push("score_x_pre", 1184);    pop_check(score_x);
    frame(1'b0, '0, '0, 1'b0);
    push("score_x_post", 640);    pop_check(score_x);
    push("score_y_post", 32);     pop_check(score_y);
    push("y4_post", 77);          pop_check(spr_y[4]);
    push("x4_untouched", 100);    pop_check(spr_x[4]);

`ifndef SCORE_AUTO_EN
    bus_write(9'd14, 32'h998);
    push("load_not_yet", 0);      pop_check(score_val());
    frame(1'b0, '0, '0, 1'b0);
    push("load_998", 'h998);      pop_check(score_val());
    bus_write(9'd14, 32'hF5C);
    frame(1'b0, '0, '0, 1'b0);
    push("load_clamp", 'h959);    pop_check(score_val());
    bus_write(9'd14, 32'h123);
    bus_write(9'd12, 32'h2);
    frame(1'b0, '0, '0, 1'b0);
    push("clear_beats_load", 0);  pop_check(score_val());
    bus_write(9'd14, 32'h456);
    frames(3);
    push("load_456", 'h456);      pop_check(score_val());
`else
    do_reset();
    bus_write(9'd12, 32'h1);
    frames(5);
    push("auto_5_frames", 0);     pop_check(score_val());
    frame(1'b0, '0, '0, 1'b0);
    push("auto_6_frames", 1);     pop_check(score_val());
    frames(5982);
    push("auto_998", 'h998);      pop_check(score_val());
    frames(6);
    push("auto_999", 'h999);      pop_check(score_val());
    frames(6);
    push("auto_wrap", 0);         pop_check(score_val());
    frames(5);
    bus_write(9'd12, 32'h3);
    frame(1'b0, '0, '0, 1'b0);
    push("clear_beats_inc", 0);   pop_check(score_val());
    frames(6);
    push("auto_after_clear", 1);  pop_check(score_val());
`endif

    // Walk animation with anim_div=2 advances every 12 frames.
    do_reset();
    bus_write(9'd13, 32'd2);
    bus_write(9'd12, 32'h1);
    frames(11);
    push("anim_11", 0);           pop_check(sprite_state);
    frames(1);
    push("anim_12", 1);           pop_check(sprite_state);
    frames(11);
    push("anim_23", 1);           pop_check(sprite_state);
    frames(1);
    push("anim_24", 2);           pop_check(sprite_state);
    frames(12);
    push("anim_36", 0);           pop_check(sprite_state);
    frames(12);
    push("anim_48", 1);           pop_check(sprite_state);
    bus_write(9'd12, 32'h0);
    frames(20);
    push("anim_frozen", 1);       pop_check(sprite_state);
    bus_write(9'd13, 32'd0);
    bus_write(9'd12, 32'h1);
    frames(5);
    push("anim_div0_5", 1);       pop_check(sprite_state);
    frames(1);
    push("anim_div0_6", 2);       pop_check(sprite_state);

    // Reset during COMMIT with a write in the same cycle.
    do_reset();
    bus_write(9'd0, 32'd777);
    bus_write(9'd12, 32'h1);
    c0 = n_commit;
    frame(1'b1, 9'd1, 32'd99, 1'b1);
    check_reset_vals("rst_commit");
    push("rst_commit_no_pulse", 0); pop_check(n_commit - c0);
    frame(1'b0, '0, '0, 1'b0);
    push("rst_shadow_x0", 100);   pop_check(spr_x[0]);
    push("rst_drop_y0", 100);     pop_check(spr_y[0]);
    push("rst_then_commit", 1);   pop_check(n_commit - c0);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
